// File: rtl/weave_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Build option: define WEAVE_ARB_SAT_EN to saturate the sum instead of wrapping it.
package weave_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;

    typedef logic [$clog2(NREQ_DEF)-1:0] tag_t;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_e;

endpackage

// File: rtl/weave_rr_picker.sv
// Rotating-priority picker: finds the first set request at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module weave_rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int IW = $clog2(NREQ);

    logic          found;
    logic [IW-1:0] cand;
    logic [IW-1:0] sel_idx;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign gnt_o = NREQ'(found) << sel_idx;
    assign idx_o = sel_idx;
    assign any_o = found;

endmodule

// File: rtl/weave_adder_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ requesters; one result register.
// Build option: WEAVE_ARB_SAT_EN saturates the sum at all-ones on overflow.
module weave_adder_arbiter
    import weave_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DW-1:0]      req_a,
    input  logic [NREQ*DW-1:0]      req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DW-1:0]           res_sum,
    output logic                    res_carry,
    output logic [$clog2(NREQ)-1:0] res_tag
);

    localparam int TW = $clog2(NREQ);

    res_state_e    state_q, state_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [TW-1:0] tag_q;
    logic [TW-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0] gnt;
    logic [TW-1:0]   gnt_idx;
    logic            any_valid;
    logic            accept;
    logic            transfer;
    logic [DW-1:0]   op_a, op_b;
    logic [DW:0]     sum_ext;

    weave_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_valid)
    );

    // Result-register FSM: state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RES_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a pop and a new grant in the same cycle keep the register full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RES_EMPTY: if (transfer)               state_d = RES_FULL;
            RES_FULL:  if (res_ready && !transfer) state_d = RES_EMPTY;
            default:                               state_d = RES_EMPTY;
        endcase
    end

    // Outputs: a new pair can be taken whenever the register is empty or draining.
    always_comb begin
        res_valid = (state_q == RES_FULL);
        accept    = (state_q == RES_EMPTY) || res_ready;
        req_ready = (accept && !rst) ? gnt : '0;
    end

    assign transfer = any_valid && accept && !rst;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_a = req_a[i*DW +: DW];
                op_b = req_b[i*DW +: DW];
            end
        end
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
`ifdef WEAVE_ARB_SAT_EN
        sum_d   = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
`else
        sum_d   = sum_ext[DW-1:0];
`endif
        carry_d = sum_ext[DW];
        ptr_d   = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
    end

    // Data and pointer only move on a transfer; a bare pop leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            tag_q   <= '0;
            ptr_q   <= '0;
        end else if (transfer) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            tag_q   <= gnt_idx;
            ptr_q   <= ptr_d;
        end
    end

    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_tag   = tag_q;

endmodule

// File: tb/tb_weave_adder_arbiter.sv
// Self-checking bench for weave_adder_arbiter: directed scenarios plus randomized
// traffic, all compared against a cycle-level reference model of the arbiter.
module tb_weave_adder_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_sum;
    logic              res_carry;
    logic [1:0]        res_tag;

    always #5 clk = ~clk;

    weave_adder_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_tag   (res_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Requester side: pending pairs, and whether a granted requester re-offers.
    bit         v[NREQ];
    logic [7:0] opa[NREQ];
    logic [7:0] opb[NREQ];
    bit         hold;

    // Reference model of the result register and round-robin pointer.
    bit m_full;
    int m_ptr;
    int m_sum;
    int m_carry;
    int m_tag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Winner for this cycle, or -1 when nothing is granted.
    function automatic int pick();
        if (rst) return -1;
        if (m_full && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: drive, check grant before the edge, update model, check outputs after.
    task automatic cycle();
        int         w;
        int         s;
        logic [3:0] exp_ready;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = v[i];
            req_a[i*DW +: DW]   = opa[i];
            req_b[i*DW +: DW]   = opb[i];
        end
        #3;
        w = pick();
        exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
        check("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_sum = 0; m_carry = 0; m_tag = 0; m_ptr = 0;
        end else if (w >= 0) begin
            s       = int'(opa[w]) + int'(opb[w]);
            m_carry = (s > 255) ? 1 : 0;
`ifdef WEAVE_ARB_SAT_EN
            m_sum   = (s > 255) ? 255 : s;
`else
            m_sum   = s % 256;
`endif
            m_tag   = w;
            m_ptr   = (w + 1) % NREQ;
            m_full  = 1;
        end else if (res_ready) begin
            m_full = 0;
        end
        #1;
        check("res_valid", {31'b0, res_valid}, m_full ? 32'd1 : 32'd0);
        check("res_sum",   {24'b0, res_sum},   32'(m_sum));
        check("res_carry", {31'b0, res_carry}, 32'(m_carry));
        check("res_tag",   {30'b0, res_tag},   32'(m_tag));
        if (w >= 0 && !hold) v[w] = 0;
    endtask

    task automatic offer(input int i, input logic [7:0] a, input logic [7:0] b);
        v[i]   = 1;
        opa[i] = a;
        opb[i] = b;
    endtask

    initial begin
        rst       = 1'b1;
        res_ready = 1'b0;
        hold      = 0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; opa[i] = 8'h00; opb[i] = 8'h00;
        end
        m_full = 0; m_sum = 0; m_carry = 0; m_tag = 0; m_ptr = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset while FULL, then all requesters valid: first grant is req 0.
        offer(0, 8'h11, 8'h22);
        cycle();
        offer(1, 8'h33, 8'h44);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t1_valid_after_rst", {31'b0, res_valid}, 32'd0);
        check("t1_sum_after_rst",   {24'b0, res_sum},   32'd0);

        // All four valid with res_ready high: tags rotate 0,1,2,3,0,1,2,3.
        hold = 1;
        res_ready = 1'b1;
        offer(0, 8'h01, 8'h02);
        offer(1, 8'h80, 8'h90);
        offer(2, 8'h7F, 8'h01);
        offer(3, 8'hFF, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("t2_tag",   {30'b0, res_tag}, 32'(k % NREQ));
            check("t2_valid", {31'b0, res_valid}, 32'd1);
        end
        hold = 0;
        for (int i = 0; i < NREQ; i++) v[i] = 0;
        cycle();

        // Backpressure with req 2 waiting, then pop and grant in the same clock.
        res_ready = 1'b0;
        offer(0, 8'h05, 8'h06);
        cycle();
        offer(2, 8'hC0, 8'h50);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t3_tag_stall", {30'b0, res_tag}, 32'd0);
        end
        res_ready = 1'b1;
        cycle();
        check("t3_tag",   {30'b0, res_tag}, 32'd2);
        check("t3_valid", {31'b0, res_valid}, 32'd1);
        cycle();

        // Overflow of F0 + 20.
        offer(0, 8'hF0, 8'h20);
        cycle();
`ifdef WEAVE_ARB_SAT_EN
        check("t4_sum", {24'b0, res_sum}, 32'h0FF);
`else
        check("t4_sum", {24'b0, res_sum}, 32'h010);
`endif
        check("t4_carry", {31'b0, res_carry}, 32'd1);
        cycle();

        // Pointer wrap: grant 3 alone, then 1 and 3 valid -> 1 wins.
        offer(3, 8'h0A, 8'h0B);
        cycle();
        check("t5_tag3", {30'b0, res_tag}, 32'd3);
        offer(1, 8'h0C, 8'h0D);
        offer(3, 8'h0E, 8'h0F);
        cycle();
        check("t5_tag1", {30'b0, res_tag}, 32'd1);
        cycle();
        cycle();

        // Sparse requests from req 1 with one-clock gaps.
        for (int k = 0; k < 5; k++) begin
            offer(1, 8'($urandom), 8'($urandom));
            cycle();
            check("t6_tag",   {30'b0, res_tag}, 32'd1);
            check("t6_valid", {31'b0, res_valid}, 32'd1);
            cycle();
            check("t6_gap",   {31'b0, res_valid}, 32'd0);
        end

        // Randomized traffic with backpressure and occasional resets.
        for (int n = 0; n < 400; n++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1)
                    offer(i, 8'($urandom), 8'($urandom));
            end
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
